// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receive-FIFO entry widths and the
// parity/stop selections used by the receiver and transmitter.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Entry layout with error bits: {parity_err, frame_err, data[7:0]}
    localparam int RX_ENTRY_W_ERR   = UART_DATA_W + 2;
    localparam int RX_ENTRY_W_NOERR = UART_DATA_W;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_sel_e;

    typedef enum logic {
        STOP_1 = 1'b0,
        STOP_2 = 1'b1
    } stop_sel_e;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage for the receive FIFO: one synchronous write port and one
// asynchronous read port. The array has no reset.
module uart_rx_fifo_mem #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    // Write the entry on the clock edge when enabled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver. Characters are captured on the
// done tick into a stage register and committed the following cycle together
// with the (one cycle late) parity status. Head outputs fall through
// combinationally; a sticky overrun flags dropped characters.
// Optional feature macro: UART_RX_FIFO_ERR_EN stores and presents the
// parity/frame error bits; when undefined entries hold the data byte only.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_tick,
    input  logic [7:0]            wr_data,
    input  logic                  wr_frame_err,
    input  logic                  wr_parity_err,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_parity_err,
    output logic                  rd_frame_err,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overrun,
    input  logic                  clr_overrun
);

`ifdef UART_RX_FIFO_ERR_EN
    localparam int ENTRY_W = RX_ENTRY_W_ERR;
`else
    localparam int ENTRY_W = RX_ENTRY_W_NOERR;
`endif
    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic                   r_stage_valid;
    logic [UART_DATA_W-1:0] r_stage_data;
    logic                   r_overrun;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_commit_ok;
    logic                   w_drop;
    logic [ENTRY_W-1:0]     w_wdata;
    logic [ENTRY_W-1:0]     w_rdata;

    // Pointer-derived flags; the extra MSB separates full from empty
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

    // A pop in the same cycle frees the slot the commit writes into
    assign w_pop       = rd_en && !w_empty;
    assign w_commit_ok = r_stage_valid && (!w_full || w_pop);
    assign w_drop      = r_stage_valid && w_full && !w_pop;

    // Capture stage: reloads on every tick so back-to-back ticks are sustained
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage_valid <= 1'b0;
            r_stage_data  <= '0;
        end else if (wr_tick) begin
            r_stage_valid <= 1'b1;
            r_stage_data  <= wr_data;
        end else begin
            r_stage_valid <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_ERR_EN
    logic r_stage_frame;

    // Frame error is only valid alongside the tick, so it rides in the stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage_frame <= 1'b0;
        end else if (wr_tick) begin
            r_stage_frame <= wr_frame_err;
        end
    end

    // Parity status arrives one cycle after the tick, i.e. at commit time
    assign w_wdata       = {wr_parity_err, r_stage_frame, r_stage_data};
    assign rd_frame_err  = !w_empty && w_rdata[UART_DATA_W];
    assign rd_parity_err = !w_empty && w_rdata[UART_DATA_W+1];
`else
    logic w_unused;

    assign w_unused      = &{1'b0, wr_frame_err, wr_parity_err};
    assign w_wdata       = r_stage_data;
    assign rd_frame_err  = 1'b0;
    assign rd_parity_err = 1'b0;
`endif

    // Pointer advance on accepted commit and on non-empty pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_commit_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    uart_rx_fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_commit_ok),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

    assign rd_data = w_empty ? '0 : w_rdata[UART_DATA_W-1:0];
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_wr_ptr - r_rd_ptr;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table-driven vectors, hand-written corner
// sequences and a random phase, all checked against a queue model.
module tb_uart_rx_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef UART_RX_FIFO_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          wr_tick;
    logic [7:0]    wr_data;
    logic          wr_frame_err;
    logic          wr_parity_err;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_parity_err;
    logic          rd_frame_err;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          clr_overrun;

    uart_rx_fifo #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_tick       (wr_tick),
        .wr_data       (wr_data),
        .wr_frame_err  (wr_frame_err),
        .wr_parity_err (wr_parity_err),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_parity_err (rd_parity_err),
        .rd_frame_err  (rd_frame_err),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: entries are {parity_err, frame_err, data}
    logic [9:0] exp_q[$];
    bit         m_overrun;
    bit         m_stage_valid;
    logic [7:0] m_stage_data;
    bit         m_stage_frame;

    typedef struct {
        bit         tick;
        logic [7:0] data;
        bit         frame;
        bit         par;
        bit         rd;
        bit         clr;
        logic [4:0] e_count;
        bit         e_empty;
        logic [7:0] e_data;
        bit         e_pe;
        bit         e_fe;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_overrun     = 1'b0;
        m_stage_valid = 1'b0;
        m_stage_data  = '0;
        m_stage_frame = 1'b0;
    endtask

    // Compare every output against the model
    task automatic check_outputs(input string tag);
        logic [9:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 10'd0;
        check({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
        check({tag, ".count"}, 32'(count), 32'(exp_q.size()));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_overrun));
        check({tag, ".rd_data"}, 32'(rd_data), 32'(head[7:0]));
        check({tag, ".rd_frame_err"}, 32'(rd_frame_err), 32'(head[8] & ERR_ON));
        check({tag, ".rd_parity_err"}, 32'(rd_parity_err), 32'(head[9] & ERR_ON));
    endtask

    // Driver: one clock with the given inputs; model updates at the edge
    task automatic cycle(input bit tick, input logic [7:0] data, input bit frame,
                         input bit par, input bit rd, input bit clr, input string tag);
        bit pop;
        bit was_full;
        bit drop;
        wr_tick       = tick;
        wr_data       = data;
        wr_frame_err  = frame;
        wr_parity_err = par;
        rd_en         = rd;
        clr_overrun   = clr;
        @(posedge clk);
        pop      = rd && (exp_q.size() != 0);
        was_full = (exp_q.size() == DEPTH);
        drop     = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (m_stage_valid) begin
            if (!was_full || pop) exp_q.push_back({par, m_stage_frame, m_stage_data});
            else drop = 1'b1;
        end
        if (drop) m_overrun = 1'b1;
        else if (clr) m_overrun = 1'b0;
        if (tick) begin
            m_stage_valid = 1'b1;
            m_stage_data  = data;
            m_stage_frame = frame;
        end else begin
            m_stage_valid = 1'b0;
        end
        @(negedge clk);
        wr_tick     = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic [7:0] last;

        reset_n       = 1'b0;
        wr_tick       = 1'b0;
        wr_data       = '0;
        wr_frame_err  = 1'b0;
        wr_parity_err = 1'b0;
        rd_en         = 1'b0;
        clr_overrun   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state and idle
        check_outputs("reset");
        idle("idle");

        // Table: single write/read, pop-while-empty with commit, back-to-back ticks
        vecs[0] = '{1, 8'hA5, 0, 0, 0, 0, 5'd0, 1, 8'h00, 0, 0};
        vecs[1] = '{0, 8'h00, 0, 1, 0, 0, 5'd1, 0, 8'hA5, 1, 0};
        vecs[2] = '{0, 8'h00, 0, 0, 1, 0, 5'd0, 1, 8'h00, 0, 0};
        vecs[3] = '{1, 8'h11, 1, 0, 0, 0, 5'd0, 1, 8'h00, 0, 0};
        vecs[4] = '{1, 8'h22, 0, 0, 1, 0, 5'd1, 0, 8'h11, 0, 1};
        vecs[5] = '{1, 8'h33, 0, 1, 0, 0, 5'd2, 0, 8'h11, 0, 1};
        vecs[6] = '{0, 8'h00, 0, 0, 0, 0, 5'd3, 0, 8'h11, 0, 1};
        vecs[7] = '{0, 8'h00, 0, 0, 1, 0, 5'd2, 0, 8'h22, 1, 0};
        vecs[8] = '{0, 8'h00, 0, 0, 1, 0, 5'd1, 0, 8'h33, 0, 0};
        vecs[9] = '{0, 8'h00, 0, 0, 1, 0, 5'd0, 1, 8'h00, 0, 0};
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].tick, vecs[i].data, vecs[i].frame, vecs[i].par,
                  vecs[i].rd, vecs[i].clr, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.t_count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d.t_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            check($sformatf("vec%0d.t_data", i), 32'(rd_data), 32'(vecs[i].e_data));
            check($sformatf("vec%0d.t_pe", i), 32'(rd_parity_err), 32'(vecs[i].e_pe & ERR_ON));
            check($sformatf("vec%0d.t_fe", i), 32'(rd_frame_err), 32'(vecs[i].e_fe & ERR_ON));
        end

        // Fill to full, overrun on 17th write (clear in the same cycle loses)
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 8'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, "fill");
        idle("fill_end");
        check("fill.full", 32'(full), 32'd1);
        check("fill.count", 32'(count), 32'd16);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "ovr_tick");
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "ovr_commit");
        check("ovr.overrun", 32'(overrun), 32'd1);
        check("ovr.count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d.data", i), 32'(rd_data), 32'(i));
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "drain");
        end
        check("drain.empty", 32'(empty), 32'd1);
        check("drain.overrun_kept", 32'(overrun), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "clr");
        check("clr.overrun", 32'(overrun), 32'd0);

        // Full with pop in the commit cycle: no overrun, 0x55 comes out last
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0, "fill2");
        idle("fill2_end");
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, "full_pop_tick");
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, "full_pop_commit");
        check("full_pop.overrun", 32'(overrun), 32'd0);
        check("full_pop.count", 32'(count), 32'd16);
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last = rd_data;
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "drain2");
        end
        check("full_pop.last", 32'(last), 32'h55);
        check("full_pop.empty", 32'(empty), 32'd1);

        // Reset mid-stream with 5 entries and a staged byte
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0, "pre_rst");
        idle("pre_rst_end");
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, "staged");
        check("pre_rst.count", 32'(count), 32'd5);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_rst");
        check("mid_rst.count", 32'(count), 32'd0);
        check("mid_rst.empty", 32'(empty), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        check_outputs("post_rst");
        cycle(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, "rst_wr");
        idle("rst_wr_commit");
        check("rst_wr.count", 32'(count), 32'd1);
        check("rst_wr.data", 32'(rd_data), 32'h7E);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "rst_rd");
        check("rst_rd.empty", 32'(empty), 32'd1);

        // Random traffic against the model, then drain
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), "rand");
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, "rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
